vep_stream: RTL and testbench

Sequential, parametrised vector element processor for the SOM neuron datapath. It stores one neuron's weight vector of DIM fixed-point elements and streams an input pattern through it one element per cycle. In a DIST pass it produces the summed absolute distance for winner search. In an UPDATE pass it applies the learning-rate-shifted correction to every weight from the buffered per-element differences. It sits between the pattern streamer and the winner-search comparator.

---
 rtl/vep_pkg.sv | 36 +++
 rtl/vep_shift_upd.sv | 51 +++++
 rtl/vep_stream.sv | 196 +++++++++++++++++++
 tb/tb_vep_stream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vep_pkg.sv
// Shared types and helpers for the vep_stream SOM vector element processor.
package vep_pkg;

    // Command op codes presented on cmd_op.
    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_DIST   = 2'd1,
        OP_UPDATE = 2'd2,
        OP_NOP    = 2'd3
    } op_e;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DIST   = 3'd2,
        ST_RESULT = 3'd3,
        ST_UPDATE = 3'd4
    } state_e;

    // Shift amounts at or above this value disable the weight correction.
    localparam int unsigned SHIFT_OFF = 32'd15;

    // Magnitude of a 17-bit signed difference. The difference range is
    // -(2^16-1)..(2^16-2^8), so the magnitude always fits in 16 bits.
    function automatic logic [15:0] abs17(input logic signed [16:0] d);
        logic [16:0] mag;
        if (d[16]) begin
            mag = 17'(-d);
        end else begin
            mag = d;
        end
        return mag[15:0];
    endfunction

endpackage

// File: rtl/vep_shift_upd.sv
// Combinational weight correction: new = weight + (d >>> shift).
// Optional macro VEP_SAT_EN clamps the result to [0, 2^W-1] instead of wrapping.
module vep_shift_upd
    import vep_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int SHIFT_W = 4,
    localparam int W      = PIX_W + FRAC_W
) (
    input  logic [W-1:0]       weight,
    input  logic signed [W:0]  d,
    input  logic [SHIFT_W-1:0] shift,
    output logic [W-1:0]       new_weight
);

    logic signed [W:0] corr_s;

    // Arithmetic barrel shift of the stored difference; large shifts zero it.
    always_comb begin
        corr_s = '0;
        if (32'(shift) >= SHIFT_OFF) begin
            corr_s = '0;
        end else begin
            corr_s = d >>> shift;
        end
    end

`ifdef VEP_SAT_EN
    logic [W+1:0] sum_s;

    // Two-bit-extended signed sum, then clamp negative to 0 and overflow to all ones.
    always_comb begin
        sum_s      = {2'b00, weight} + {corr_s[W], corr_s};
        new_weight = '0;
        if (sum_s[W+1]) begin
            new_weight = '0;
        end else if (sum_s[W]) begin
            new_weight = '1;
        end else begin
            new_weight = sum_s[W-1:0];
        end
    end
`else
    // Modulo-2^W sum; the correction's sign bit drops out of the truncated add.
    always_comb begin
        new_weight = weight + corr_s[W-1:0];
    end
`endif

endmodule

// File: rtl/vep_stream.sv
// vep_stream: stores one neuron weight vector, computes the summed absolute
// distance to a streamed pattern (DIST) and applies the shifted correction
// from the buffered differences (UPDATE). Optional macro: VEP_SAT_EN.
module vep_stream
    import vep_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int FRAC_W  = 8,
    parameter int DIM     = 16,
    parameter int SHIFT_W = 4,
    localparam int W      = PIX_W + FRAC_W,
    localparam int IDX_W  = $clog2(DIM),
    localparam int ACC_W  = W + $clog2(DIM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_dist,
    output logic               upd_done,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [W-1:0]       rd_data
);

    state_e              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [ACC_W-1:0]    acc_r;
    logic [SHIFT_W-1:0]  shift_r;
    logic                cmd_ready_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic                upd_done_r;
    logic [W-1:0]        weight_r [DIM];
    logic signed [W:0]   diff_r   [DIM];

    logic                cmd_fire_s;
    logic                in_fire_s;
    logic                last_s;
    logic [W-1:0]        cur_w_s;
    logic [PIX_W-1:0]    pix_s;
    logic signed [W:0]   d_s;
    logic [W-1:0]        abs_d_s;
    logic [W-1:0]        upd_w_s;

    assign cmd_fire_s = cmd_valid & cmd_ready_r;
    assign in_fire_s  = in_valid & in_ready_r;
    assign last_s     = (idx_r == IDX_W'(DIM - 1));
    assign cur_w_s    = weight_r[idx_r];
    assign pix_s      = in_data[PIX_W-1:0];
    assign d_s        = $signed({1'b0, pix_s, {FRAC_W{1'b0}}}) - $signed({1'b0, cur_w_s});

    generate
        if (W == 16) begin : g_abs17
            assign abs_d_s = abs17(d_s);
        end else begin : g_abs_gen
            assign abs_d_s = d_s[W] ? W'(-d_s) : d_s[W-1:0];
        end
    endgenerate

    vep_shift_upd #(
        .PIX_W   (PIX_W),
        .FRAC_W  (FRAC_W),
        .SHIFT_W (SHIFT_W)
    ) u_shift_upd (
        .weight     (cur_w_s),
        .d          (diff_r[idx_r]),
        .shift      (shift_r),
        .new_weight (upd_w_s)
    );

    assign cmd_ready = cmd_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_dist  = acc_r;
    assign upd_done  = upd_done_r;
    assign rd_data   = weight_r[rd_addr];

    // Controller FSM with index, accumulator and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            acc_r       <= '0;
            shift_r     <= '0;
            cmd_ready_r <= 1'b1;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            upd_done_r  <= 1'b0;
        end else begin
            upd_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        idx_r <= '0;
                        case (op_e'(cmd_op))
                            OP_LOAD: begin
                                state_r     <= ST_LOAD;
                                cmd_ready_r <= 1'b0;
                                in_ready_r  <= 1'b1;
                            end
                            OP_DIST: begin
                                state_r     <= ST_DIST;
                                acc_r       <= '0;
                                cmd_ready_r <= 1'b0;
                                in_ready_r  <= 1'b1;
                            end
                            OP_UPDATE: begin
                                state_r     <= ST_UPDATE;
                                shift_r     <= cmd_shift;
                                cmd_ready_r <= 1'b0;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (in_fire_s) begin
                        idx_r <= idx_r + IDX_W'(1);
                        if (last_s) begin
                            state_r     <= ST_IDLE;
                            cmd_ready_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end
                    end
                end
                ST_DIST: begin
                    if (in_fire_s) begin
                        acc_r <= acc_r + ACC_W'(abs_d_s);
                        idx_r <= idx_r + IDX_W'(1);
                        if (last_s) begin
                            state_r     <= ST_RESULT;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    idx_r <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        state_r     <= ST_IDLE;
                        upd_done_r  <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= '0;
                    cmd_ready_r <= 1'b1;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Weight buffer: written by LOAD elements and by each UPDATE step.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                weight_r[i] <= '0;
            end
        end else if ((state_r == ST_LOAD) && in_fire_s) begin
            weight_r[idx_r] <= in_data;
        end else if (state_r == ST_UPDATE) begin
            weight_r[idx_r] <= upd_w_s;
        end
    end

    // Difference buffer: captured during DIST, kept across LOAD for later UPDATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                diff_r[i] <= '0;
            end
        end else if ((state_r == ST_DIST) && in_fire_s) begin
            diff_r[idx_r] <= d_s;
        end
    end

endmodule

// File: tb/tb_vep_stream.sv
// Directed self-checking bench for vep_stream with DIM=4, PIX_W=FRAC_W=8.
module tb_vep_stream;

    localparam int PIX_W   = 8;
    localparam int FRAC_W  = 8;
    localparam int DIM     = 4;
    localparam int SHIFT_W = 4;
    localparam int W       = 16;
    localparam int IDX_W   = 2;
    localparam int ACC_W   = 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [SHIFT_W-1:0] cmd_shift;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_dist;
    logic               upd_done;
    logic [IDX_W-1:0]   rd_addr;
    logic [W-1:0]       rd_data;

    int checks_r   = 0;
    int failures_r = 0;

    vep_stream #(
        .PIX_W   (PIX_W),
        .FRAC_W  (FRAC_W),
        .DIM     (DIM),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_shift (cmd_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dist  (out_dist),
        .upd_done  (upd_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [SHIFT_W-1:0] sh);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_shift = sh;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic load_vec(input logic [3:0][15:0] v);
        send_cmd(2'd0, 4'd0);
        for (int i = 0; i < DIM; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic dist_vec(input logic [3:0][7:0] p);
        send_cmd(2'd1, 4'd0);
        for (int i = 0; i < DIM; i++) begin
            in_valid = 1'b1;
            in_data  = {8'h00, p[i]};
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_weights(input string tag, input logic [3:0][15:0] exp);
        for (int i = 0; i < DIM; i++) begin
            rd_addr = IDX_W'(i);
            #1;
            check_val($sformatf("%s_w%0d", tag, i), {16'h0000, rd_data}, {16'h0000, exp[i]});
        end
    endtask

    // Issues UPDATE, checks the pre-write read of element 0 and the upd_done timing.
    task automatic run_update(input string tag, input logic [SHIFT_W-1:0] sh, input logic [15:0] pre0);
        send_cmd(2'd2, sh);
        rd_addr = 2'd0;
        #1;
        check_val($sformatf("%s_prewrite", tag), {16'h0000, rd_data}, {16'h0000, pre0});
        for (int k = 1; k <= DIM; k++) begin
            step();
            check_val($sformatf("%s_done_c%0d", tag, k), {31'd0, upd_done}, {31'd0, (k == DIM)});
        end
        check_val($sformatf("%s_ready", tag), {31'd0, cmd_ready}, 32'd1);
        step();
        check_val($sformatf("%s_done_pulse", tag), {31'd0, upd_done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_shift = 4'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        rd_addr   = 2'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_dist",  {14'd0, out_dist},  32'd0);
        check_val("rst_upd_done",  {31'd0, upd_done},  32'd0);
        check_weights("rst", {16'h0000, 16'h0000, 16'h0000, 16'h0000});

        // Reserved op is accepted and leaves the block idle
        send_cmd(2'd3, 4'd0);
        check_val("nop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("nop_in_ready",  {31'd0, in_ready},  32'd0);

        // LOAD and read-back
        load_vec({16'h4000, 16'h3000, 16'h2000, 16'h1000});
        check_val("load_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_weights("load", {16'h4000, 16'h3000, 16'h2000, 16'h1000});

        // DIST with a one-cycle in_valid gap after the 2nd element
        send_cmd(2'd1, 4'd0);
        in_valid = 1'b1; in_data = 16'h0020; step();
        in_valid = 1'b1; in_data = 16'h0010; step();
        in_valid = 1'b0; in_data = 16'h00FF; step();
        in_valid = 1'b1; in_data = 16'h0030; step();
        in_valid = 1'b1; in_data = 16'h0040; step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("dist_valid_hold%0d", c), {31'd0, out_valid}, 32'd1);
            check_val($sformatf("dist_sum_hold%0d", c), {14'd0, out_dist}, 32'h2000);
            check_val($sformatf("dist_cmd_busy%0d", c), {31'd0, cmd_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val("dist_valid_drop", {31'd0, out_valid}, 32'd0);
        check_val("dist_cmd_ready",  {31'd0, cmd_ready}, 32'd1);

        // UPDATE shift=1, then shift=15 (no change)
        run_update("upd1", 4'd1, 16'h1000);
        check_weights("upd1", {16'h4000, 16'h3000, 16'h1800, 16'h1800});
        run_update("upd15", 4'd15, 16'h1800);
        check_weights("upd15", {16'h4000, 16'h3000, 16'h1800, 16'h1800});

        // Extreme differences: d0=-0xFFFF, d1=+0xFF00
        load_vec({16'h0000, 16'h0000, 16'h0000, 16'hFFFF});
        dist_vec({8'h00, 8'h00, 8'hFF, 8'h00});
        check_val("ext_sum", {14'd0, out_dist}, 32'h1FEFF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        run_update("ext0", 4'd0, 16'hFFFF);
        check_weights("ext0", {16'h0000, 16'h0000, 16'hFF00, 16'h0000});

        // Reload without clearing diffs, then force overflow in both directions
        load_vec({16'h0000, 16'h0000, 16'hFF00, 16'h0000});
        run_update("ovf", 4'd0, 16'h0000);
`ifdef VEP_SAT_EN
        check_weights("ovf", {16'h0000, 16'h0000, 16'hFFFF, 16'h0000});
`else
        check_weights("ovf", {16'h0000, 16'h0000, 16'hFE00, 16'h0001});
`endif

        // Reset asserted during the 2nd DIST element
        send_cmd(2'd1, 4'd0);
        in_valid = 1'b1; in_data = 16'h0020; step();
        in_data = 16'h0010; rst = 1'b1; step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_val("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("midrst_in_ready",  {31'd0, in_ready},  32'd0);
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_out_dist",  {14'd0, out_dist},  32'd0);
        check_weights("midrst", {16'h0000, 16'h0000, 16'h0000, 16'h0000});

        // UPDATE after reset uses a zeroed diff buffer
        load_vec({16'h0400, 16'h0300, 16'h0200, 16'h0100});
        run_update("zdiff", 4'd0, 16'h0100);
        check_weights("zdiff", {16'h0400, 16'h0300, 16'h0200, 16'h0100});

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
